flash_rate_gen: RTL
===================

Name: flash_rate_gen

Overview:
- Upstream timing stage for the bicycle-light FSM.
- Converts the raw-level fast/slow buttons into a saturating rate index and emits a one-cycle flash tick.
- Tick period = BASE_PERIOD << rate_idx. The light FSM toggles the flashing LED on each tick and pulses restart whenever it enters a flash mode.
- Fast halves the flash period; slow doubles it.

Parameters:
- BASE_PERIOD, 25000000, clock cycles per tick at rate_idx=0 (fastest); benches override to 4.
- IDX_W, 3, width of rate_idx.
- MAX_IDX, 4, largest (slowest) rate index; must be less than 2**IDX_W.
- DEFAULT_IDX, 2, rate index loaded at reset; must be at most MAX_IDX.
- CNT_W, 32, period counter width; must hold BASE_PERIOD<<MAX_IDX.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- fast  in  1  fast button level, already synchronized; high = pressed.
- slow  in  1  slow button level, already synchronized; high = pressed.
- restart  in  1  one-cycle pulse from the light FSM; restarts the current period.
- tick  out  1  registered one-cycle pulse at the end of each period.
- rate_idx  out  IDX_W  current rate index (0 = fastest).
- at_fastest  out  1  high when rate_idx==0.
- at_slowest  out  1  high when rate_idx==MAX_IDX.

Behaviour:
- Reset (rst_n low at a clk edge):
  - rate_idx=DEFAULT_IDX, cnt=0, tick=0.
  - fast_q=1, slow_q=1, so a button held through reset produces no press on release.
  - at_fastest and at_slowest are decoded combinationally from rate_idx.
- Edge detect:
  - fast_q/slow_q register the previous input levels.
  - A press is in=1 and q=0, i.e. one press per rising edge of the level.
  - Holding a button gives exactly one step.
- Rate update (registered, takes effect the edge after the press is seen):
  - fast press only: rate_idx decrements, saturating at 0.
  - slow press only: rate_idx increments, saturating at MAX_IDX.
  - fast and slow pressed in the same cycle: no change and no counter restart.
- Period counter: P = BASE_PERIOD << rate_idx, using the current rate_idx. Per edge, in priority order:
  1. restart, or an actual rate_idx change: cnt<=0, tick<=0.
  2. cnt==P-1: cnt<=0, tick<=1.
  3. otherwise: cnt<=cnt+1, tick<=0.
- A saturated press (no index change) does not restart the counter.
- Tick timing:
  - With no events, tick is high for exactly one cycle every P cycles.
  - The first tick after reset release or a restart is high in the cycle after the P-th edge following it.
  - The first tick after a rate change follows the same rule, using the new P.
- A rate change and restart in the same cycle:
  - Both take effect: the index updates and the counter zeroes.
  - The next tick comes after the new P.
- Reset mid-count overrides everything. The index returns to DEFAULT_IDX even if a press occurs in the same cycle.

Test Plan (BASE_PERIOD=4, MAX_IDX=3, DEFAULT_IDX=1):
- Reset, then idle 40 cycles -> rate_idx=1, ticks exactly every 8 cycles; first tick in cycle 8 after reset release; each tick one cycle wide.
- Hold slow high for 20 cycles -> rate_idx steps 1->2 once only. Next tick 16 cycles after the step, then every 16 cycles.
- Four separate slow presses from idx 2 -> idx reaches 3, at_slowest=1. Further presses leave it at 3, counter not restarted, tick spacing stays 32.
- Fast presses from idx 3 down to 0, plus one extra -> ticks every 4 cycles, at_fastest=1, extra press ignored.
- fast and slow rising in the same cycle -> rate_idx unchanged, tick phase undisturbed.
- Pulse restart at cnt=5 of an 8-cycle period; then hold fast across a reset pulse -> the restart delays the next tick to 8 cycles after the pulse. After the reset, rate_idx=1 with no step on release.

Source files
------------

// File: rtl/flash_rate_gen.sv
// flash_rate_gen: button-driven saturating rate index and periodic one-cycle flash tick
module flash_rate_gen #(
  parameter int BASE_PERIOD = 25000000,
  parameter int IDX_W = 3,
  parameter int MAX_IDX = 4,
  parameter int DEFAULT_IDX = 2,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fast,
  input  logic slow,
  input  logic restart,
  output logic tick,
  output logic [IDX_W-1:0] rate_idx,
  output logic at_fastest,
  output logic at_slowest
);
  logic fast_q, slow_q, fast_p, slow_p, dn, up;
  logic [CNT_W-1:0] cnt, period;
  always_comb begin
    fast_p = fast & ~fast_q;
    slow_p = slow & ~slow_q;
    dn = fast_p & ~slow_p & ~at_fastest;
    up = slow_p & ~fast_p & ~at_slowest;
    period = CNT_W'(BASE_PERIOD) << rate_idx;
    at_fastest = rate_idx == '0;
    at_slowest = rate_idx == IDX_W'(MAX_IDX);
  end
  // a saturated press leaves dn/up low, so it neither steps nor restarts the period
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fast_q <= 1'b1;
      slow_q <= 1'b1;
      rate_idx <= IDX_W'(DEFAULT_IDX);
      cnt <= '0;
      tick <= 1'b0;
    end else begin
      fast_q <= fast;
      slow_q <= slow;
      rate_idx <= dn ? rate_idx - IDX_W'(1) : up ? rate_idx + IDX_W'(1) : rate_idx;
      cnt <= (restart | dn | up | (cnt == period - CNT_W'(1))) ? '0 : cnt + CNT_W'(1);
      tick <= ~(restart | dn | up) & (cnt == period - CNT_W'(1));
    end
  end
endmodule
